// File: rtl/fnd_pkg.sv
// Shared FND definitions: segment patterns, scan slot indices, settle FSM states
// and the common-enable decoder used by the scan receiver.
package fnd_pkg;

   localparam int unsigned NUM_SLOTS = 6;

   // {a,b,c,d,e,f,g}, active-high
   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h73;

   localparam logic [2:0] SLOT_SEC_ONES = 3'd0;
   localparam logic [2:0] SLOT_SEC_TENS = 3'd1;
   localparam logic [2:0] SLOT_MIN_ONES = 3'd2;
   localparam logic [2:0] SLOT_MIN_TENS = 3'd3;
   localparam logic [2:0] SLOT_HR_ONES  = 3'd4;
   localparam logic [2:0] SLOT_HR_TENS  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } settle_state_e;

   typedef struct packed {
      logic       valid;
      logic       blank;
      logic [2:0] idx;
   } slot_dec_t;

   // Active-low commons: one zero selects a slot, none is blank, more is invalid
   function automatic slot_dec_t decode_enb(input logic [5:0] enb);
      slot_dec_t r;
      r = '0;
      case (enb)
         6'b111110: begin r.valid = 1'b1; r.idx = SLOT_SEC_ONES; end
         6'b111101: begin r.valid = 1'b1; r.idx = SLOT_SEC_TENS; end
         6'b111011: begin r.valid = 1'b1; r.idx = SLOT_MIN_ONES; end
         6'b110111: begin r.valid = 1'b1; r.idx = SLOT_MIN_TENS; end
         6'b101111: begin r.valid = 1'b1; r.idx = SLOT_HR_ONES;  end
         6'b011111: begin r.valid = 1'b1; r.idx = SLOT_HR_TENS;  end
         6'b111111: r.blank = 1'b1;
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fnd_seg2bcd.sv
// Combinational 7-segment pattern to BCD nibble; unknown patterns give F.
module fnd_seg2bcd
   import fnd_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       valid_c_o,
   output logic [3:0] nibble_c_o
);

   always_comb begin
      valid_c_o  = 1'b1;
      nibble_c_o = 4'hF;
      case (seg_i)
         SEG_0:   nibble_c_o = 4'd0;
         SEG_1:   nibble_c_o = 4'd1;
         SEG_2:   nibble_c_o = 4'd2;
         SEG_3:   nibble_c_o = 4'd3;
         SEG_4:   nibble_c_o = 4'd4;
         SEG_5:   nibble_c_o = 4'd5;
         SEG_6:   nibble_c_o = 4'd6;
         SEG_7:   nibble_c_o = 4'd7;
         SEG_8:   nibble_c_o = 4'd8;
         SEG_9:   nibble_c_o = 4'd9;
         default: valid_c_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/fnd_scan_rx.sv
// Multiplexed FND scan receiver: captures each digit slot once it has settled,
// then publishes a range-checked hh:mm:ss frame when all six slots are in.
module fnd_scan_rx
   import fnd_pkg::*;
#(
   parameter int unsigned STABLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   input  logic [5:0]  i_seg_enb,
   output logic [4:0]  o_hr,
   output logic [5:0]  o_min,
   output logic [5:0]  o_sec,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic        o_frame_valid,
   output logic        o_err,
   output logic        o_stall
);

   localparam int unsigned IN_W = 14;
   localparam int unsigned SCW  = $clog2(STABLE_CYC);
   localparam int unsigned IW   = $clog2(TIMEOUT_CYC);
   localparam logic [IN_W-1:0] IN_RST = IN_W'(6'h3F);

   logic [IN_W-1:0] in_s1_q, in_s2_q, in_prev_q;
   logic [6:0]      seg_s;
   logic            dp_s;
   logic [5:0]      enb_s;

   settle_state_e   state_q, state_d;
   logic [SCW-1:0]  scnt_q, scnt_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic [5:0]      mask_q, mask_d;
   logic            acc_q, acc_d;
   logic [23:0]     dig_q, dig_d;
   logic [5:0]      sdp_q, sdp_d;

   logic [4:0]      hr_q, hr_d;
   logic [5:0]      min_q, min_d, sec_q, sec_d, dpo_q, dpo_d;
   logic [23:0]     digits_q, digits_d;
   logic            fv_q, fv_d, oerr_q, oerr_d, stall_q, stall_d;

   logic            seg_ok_c;
   logic [3:0]      seg_nib_c;
   slot_dec_t       slot_c;
   logic            in_chg_c, enb_chg_c, cap_c, timeout_c, publish_c;
   logic [7:0]      hr_c, min_c, sec_c;
   logic            nib_bad_c, range_bad_c;

   assign {seg_s, dp_s, enb_s} = in_s2_q;
   assign slot_c    = decode_enb(enb_s);
   assign in_chg_c  = (in_s2_q != in_prev_q);
   assign enb_chg_c = (enb_s != in_prev_q[5:0]);

   fnd_seg2bcd u_seg2bcd (
      .seg_i      (seg_s),
      .valid_c_o  (seg_ok_c),
      .nibble_c_o (seg_nib_c)
   );

   // Frame value conversion and plausibility check on the captured digits
   assign hr_c  = 8'(dig_q[23:20]) * 8'd10 + 8'(dig_q[19:16]);
   assign min_c = 8'(dig_q[15:12]) * 8'd10 + 8'(dig_q[11:8]);
   assign sec_c = 8'(dig_q[7:4])   * 8'd10 + 8'(dig_q[3:0]);
   assign nib_bad_c = (dig_q[3:0]   > 4'd9) | (dig_q[7:4]   > 4'd9) |
                      (dig_q[11:8]  > 4'd9) | (dig_q[15:12] > 4'd9) |
                      (dig_q[19:16] > 4'd9) | (dig_q[23:20] > 4'd9);
   assign range_bad_c = nib_bad_c | (hr_c > 8'd23) | (min_c > 8'd59) | (sec_c > 8'd59);

   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      idle_d    = idle_q;
      mask_d    = mask_q;
      acc_d     = acc_q;
      dig_d     = dig_q;
      sdp_d     = sdp_q;
      hr_d      = hr_q;
      min_d     = min_q;
      sec_d     = sec_q;
      digits_d  = digits_q;
      dpo_d     = dpo_q;
      fv_d      = 1'b0;
      oerr_d    = oerr_q;
      stall_d   = stall_q;
      cap_c     = 1'b0;
      timeout_c = 1'b0;
      publish_c = 1'b0;

      // One capture per slot visit, once the inputs have held for STABLE_CYC
      case (state_q)
         ST_IDLE, ST_HELD: begin
            if (in_chg_c) begin
               state_d = ST_SETTLE;
               scnt_d  = '0;
            end
         end
         ST_SETTLE: begin
            if (in_chg_c) begin
               scnt_d = '0;
            end else if (scnt_q == SCW'(STABLE_CYC - 1)) begin
               cap_c   = 1'b1;
               state_d = ST_HELD;
            end else begin
               scnt_d = scnt_q + SCW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (enb_chg_c) begin
         idle_d  = '0;
         stall_d = 1'b0;
      end else if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
         timeout_c = 1'b1;
         stall_d   = 1'b1;
      end else begin
         idle_d = idle_q + IW'(1);
      end

      publish_c = (mask_q == 6'h3F) && !timeout_c;

      if (timeout_c) begin
         mask_d = '0;
         acc_d  = 1'b0;
      end

      if (publish_c) begin
         mask_d   = '0;
         acc_d    = 1'b0;
         fv_d     = 1'b1;
         digits_d = dig_q;
         dpo_d    = sdp_q;
         if (range_bad_c) begin
            oerr_d = 1'b1;
         end else begin
            oerr_d = acc_q;
            hr_d   = 5'(hr_c);
            min_d  = 6'(min_c);
            sec_d  = 6'(sec_c);
         end
      end

      // Capture lands after the publish clear so it starts the next frame
      if (cap_c && !timeout_c) begin
         if (slot_c.valid) begin
            dig_d[{slot_c.idx, 2'b00} +: 4] = seg_nib_c;
            sdp_d[slot_c.idx]  = dp_s;
            mask_d[slot_c.idx] = 1'b1;
            if (!seg_ok_c) acc_d = 1'b1;
         end else if (!slot_c.blank) begin
            acc_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_s1_q   <= IN_RST;
         in_s2_q   <= IN_RST;
         in_prev_q <= IN_RST;
         state_q   <= ST_IDLE;
         scnt_q    <= '0;
         idle_q    <= '0;
         mask_q    <= '0;
         acc_q     <= 1'b0;
         dig_q     <= '0;
         sdp_q     <= '0;
         hr_q      <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         digits_q  <= '0;
         dpo_q     <= '0;
         fv_q      <= 1'b0;
         oerr_q    <= 1'b0;
         stall_q   <= 1'b0;
      end else begin
         in_s1_q   <= {i_seg, i_seg_dp, i_seg_enb};
         in_s2_q   <= in_s1_q;
         in_prev_q <= in_s2_q;
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         idle_q    <= idle_d;
         mask_q    <= mask_d;
         acc_q     <= acc_d;
         dig_q     <= dig_d;
         sdp_q     <= sdp_d;
         hr_q      <= hr_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         digits_q  <= digits_d;
         dpo_q     <= dpo_d;
         fv_q      <= fv_d;
         oerr_q    <= oerr_d;
         stall_q   <= stall_d;
      end
   end

   assign o_hr          = hr_q;
   assign o_min         = min_q;
   assign o_sec         = sec_q;
   assign o_digits      = digits_q;
   assign o_dp          = dpo_q;
   assign o_frame_valid = fv_q;
   assign o_err         = oerr_q;
   assign o_stall       = stall_q;

endmodule
